vga_timing_generator: RTL



---
 rtl/vga_timing_generator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_timing_generator.sv
// Raster timing generator: horizontal/vertical counters with registered
// sync, coordinate and blanking outputs for a VGA-style display.
// Each axis runs front porch, sync, back porch, then visible, from count 0.
module vga_timing_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = 11,
    parameter int XW         = 10,
    parameter int YW         = 10
) (
    input  logic          pixelclock_i,
    input  logic          reset_i,
    input  logic          enable_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          video_on_o,
    output logic          line_end_o,
    output logic          frame_start_o
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_BLANK + H_VISIBLE;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = V_BLANK + V_VISIBLE;

    localparam logic [CW-1:0] H_SYNC_START = CW'(H_FP);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(H_FP + H_SYNC);
    localparam logic [CW-1:0] H_BLANK_C    = CW'(H_BLANK);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_FP);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(V_FP + V_SYNC);
    localparam logic [CW-1:0] V_BLANK_C    = CW'(V_BLANK);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE          = CW'(1);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          video_on_q, video_on_d;
    logic          line_end_q, line_end_d;
    logic          frame_start_q, frame_start_d;

    logic [CW-1:0] x_full;
    logic [CW-1:0] y_full;
    logic          h_vis;
    logic          v_vis;

    // Next counter position: advance one pixel when enabled, hold otherwise.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (enable_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
            end else begin
                h_d = h_q + ONE;
            end
        end
    end

    // Decode outputs from the next position so registered outputs line up
    // with the counters on the same edge; a held position decodes unchanged.
    always_comb begin
        h_vis         = (h_d >= H_BLANK_C);
        v_vis         = (v_d >= V_BLANK_C);
        x_full        = h_d - H_BLANK_C;
        y_full        = v_d - V_BLANK_C;
        hsync_d       = ((h_d >= H_SYNC_START) && (h_d < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = ((v_d >= V_SYNC_START) && (v_d < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        x_d           = h_vis ? XW'(x_full) : '0;
        y_d           = v_vis ? YW'(y_full) : '0;
        video_on_d    = h_vis && v_vis;
        line_end_d    = (h_d == H_LAST);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    // Counter and output registers; synchronous active-low reset wins over enable.
    always_ff @(posedge pixelclock_i) begin
        if (!reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign video_on_o    = video_on_q;
    assign line_end_o    = line_end_q;
    assign frame_start_o = frame_start_q;

endmodule
